// File: rtl/sar_pkg.sv
// ============================================================================
//  Module      : sar_pkg
//  Description : Shared types and helpers for the successive-approximation search engine.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sar_pkg;

    localparam int c_sar_width = 4;
    localparam int c_sar_idx_w = $clog2(c_sar_width);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRIAL = 2'd1,
        DONE  = 2'd2
    } sar_state_t;

    // Index register width for an arbitrary WIDTH; never narrower than one bit.
    function automatic int idx_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

    // Exactly one of the three comparator verdicts must be asserted.
    function automatic logic onehot3_ok(input logic gt, input logic lt, input logic eq);
        return (gt ^ lt ^ eq) & ~(gt & lt & eq);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sar_search_if.sv
// ============================================================================
//  Module      : sar_search_if
//  Description : Request / comparator / result bundle between a SAR engine and its user.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sar_search_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             cmp_gt;
    logic             cmp_lt;
    logic             cmp_eq;
    logic [WIDTH-1:0] trial;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cmp_err;

    modport master (
        output start, cmp_gt, cmp_lt, cmp_eq,
        input  trial, busy, done, result, cmp_err
    );

    modport slave (
        input  start, cmp_gt, cmp_lt, cmp_eq,
        output trial, busy, done, result, cmp_err
    );
endinterface

`default_nettype wire

// File: rtl/sar_search.sv
// ============================================================================
//  Module      : sar_search
//  Description : Resolves an unknown WIDTH-bit target MSB-first through an external
//                comparator. Optional macro SAR_EARLY_EXIT_EN ends on an eq verdict.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sar_search
    import sar_pkg::*;
#(
    parameter int WIDTH = c_sar_width
) (
    input  wire logic       clk,
    input  wire logic       rst,
    sar_search_if.slave     bus
);

    localparam int               IDX_W       = idx_width(WIDTH);
    localparam logic [WIDTH-1:0] c_trial_msb = WIDTH'(1) << (WIDTH - 1);
    localparam logic [IDX_W-1:0] c_idx_top   = IDX_W'(WIDTH - 1);

    sar_state_t       r_state;
    sar_state_t       w_state_nxt;
    logic [WIDTH-1:0] r_trial;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_result;
    logic             r_cmp_err;

    logic             w_verdict_ok;
    logic             w_last_bit;
    logic             w_eq_exit;
    logic [WIDTH-1:0] w_bit;
    logic [WIDTH-1:0] w_trial_upd;

    assign w_verdict_ok = onehot3_ok(bus.cmp_gt, bus.cmp_lt, bus.cmp_eq);
    assign w_last_bit   = (r_idx == '0);
    assign w_bit        = WIDTH'(1) << r_idx;
    // Only an lt verdict clears the bit under test; gt and eq both keep it.
    assign w_trial_upd  = bus.cmp_lt ? (r_trial & ~w_bit) : r_trial;

`ifdef SAR_EARLY_EXIT_EN
    assign w_eq_exit = bus.cmp_eq;
`else
    assign w_eq_exit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_nxt = TRIAL;
                end
            end
            TRIAL: begin
                if (!w_verdict_ok || w_eq_exit || w_last_bit) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        bus.busy    = (r_state == TRIAL);
        bus.done    = (r_state == DONE);
        bus.trial   = r_trial;
        bus.result  = r_result;
        bus.cmp_err = r_cmp_err;
    end

    // Search datapath: trial, bit index, result and error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_trial   <= '0;
            r_idx     <= c_idx_top;
            r_result  <= '0;
            r_cmp_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_trial   <= c_trial_msb;
                        r_idx     <= c_idx_top;
                        r_result  <= '0;
                        r_cmp_err <= 1'b0;
                    end
                end
                TRIAL: begin
                    if (!w_verdict_ok) begin
                        r_result  <= '0;
                        r_cmp_err <= 1'b1;
                    end else if (w_eq_exit) begin
                        r_result <= r_trial;
                    end else if (w_last_bit) begin
                        r_trial  <= w_trial_upd;
                        r_result <= w_trial_upd;
                    end else begin
                        r_trial <= w_trial_upd | (w_bit >> 1);
                        r_idx   <= r_idx - IDX_W'(1);
                    end
                end
                DONE: begin
                    r_trial <= '0;
                end
                default: begin
                    r_trial <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sar_search.sv
// ============================================================================
//  Module      : tb_sar_search
//  Description : Closed-loop bench: comparator model around sar_search, checked against
//                an arithmetic model of the expected trial sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sar_search;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] target = '0;
    logic [1:0]   force_bad = 2'd0;   // 1: gt and lt both high, 2: no verdict
    int           total = 0;
    int           bad = 0;

    sar_search_if #(.WIDTH(W)) bus ();

    sar_search #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Comparator closing the loop around the engine
    always_comb begin
        if (force_bad == 2'd1) begin
            bus.cmp_gt = 1'b1; bus.cmp_lt = 1'b1; bus.cmp_eq = 1'b0;
        end else if (force_bad == 2'd2) begin
            bus.cmp_gt = 1'b0; bus.cmp_lt = 1'b0; bus.cmp_eq = 1'b0;
        end else begin
            bus.cmp_gt = (target > bus.trial);
            bus.cmp_lt = (target < bus.trial);
            bus.cmp_eq = (target == bus.trial);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Number of trial cycles the model predicts for a target.
    function automatic int exp_trials(input int tgt);
`ifdef SAR_EARLY_EXIT_EN
        for (int k = 0; k < W; k++) begin
            if (tgt[k]) return W - k;
        end
        return W;
`else
        return W + 0 * tgt;
`endif
    endfunction

    // Step k tests bit k: target's bits above k, bit k set, everything below cleared.
    function automatic logic [W-1:0] model_trial(input int tgt, input int k);
        return W'(((tgt >> (k + 1)) << (k + 1)) | (1 << k));
    endfunction

    task automatic run_search(input int tgt);
        int steps;
        logic [W-1:0] exp_t;
        target = W'(tgt);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        steps = 0;
        check("err_clr_on_start", bus.cmp_err, 0);
        check("res_clr_on_start", bus.result, 0);
        for (int k = W - 1; k >= 0; k--) begin
            exp_t = model_trial(tgt, k);
            check("busy_in_trial", bus.busy, 1);
            check("done_in_trial", bus.done, 0);
            check("trial_value", bus.trial, exp_t);
            steps++;
            tick();
`ifdef SAR_EARLY_EXIT_EN
            if (int'(exp_t) == tgt) break;
`endif
        end
        check("trial_count", steps, exp_trials(tgt));
        check("done_pulse", bus.done, 1);
        check("busy_at_done", bus.busy, 0);
        check("result", bus.result, tgt);
        check("cmp_err_clean", bus.cmp_err, 0);
        tick();
        check("done_one_cycle", bus.done, 0);
        check("trial_idle_zero", bus.trial, 0);
        check("result_held", bus.result, tgt);
    endtask

    initial begin
        bus.start = 1'b0;
        #2;
        check("rst_trial", bus.trial, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_result", bus.result, 0);
        check("rst_cmp_err", bus.cmp_err, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Directed targets, including both ends of the range
        run_search(11);
        run_search(0);
        run_search(15);
        run_search(8);

        // Random targets
        for (int n = 0; n < 20; n++) begin
            run_search(int'($urandom_range(0, (1 << W) - 1)));
        end

        // Conflicting verdict on the second trial cycle
        target = W'(5);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        force_bad = 2'd1;
        tick();
        force_bad = 2'd0;
        check("bad_gt_lt_done", bus.done, 1);
        check("bad_gt_lt_result", bus.result, 0);
        check("bad_gt_lt_err", bus.cmp_err, 1);
        tick();
        check("err_held_idle", bus.cmp_err, 1);
        run_search(6);

        // Missing verdict on the first trial cycle
        target = W'(3);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        force_bad = 2'd2;
        tick();
        force_bad = 2'd0;
        check("no_verdict_done", bus.done, 1);
        check("no_verdict_err", bus.cmp_err, 1);
        check("no_verdict_result", bus.result, 0);
        tick();

        // Asynchronous reset in the third trial cycle
        target = W'(1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        check("pre_rst_busy", bus.busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_trial", bus.trial, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_done", bus.done, 0);
        check("arst_result", bus.result, 0);
        check("arst_cmp_err", bus.cmp_err, 0);
        tick();
        check("arst_no_done", bus.done, 0);
        rst = 1'b0;
        tick();
        check("post_rst_no_done", bus.done, 0);
        run_search(13);

        // start held high: the DONE cycle ignores it, the following IDLE cycle accepts it
        target = W'(1);
        bus.start = 1'b1;
        tick();
        for (int i = 1; i <= W; i++) begin
            check("held_busy", bus.busy, 1);
        end
        for (int i = 1; i < W; i++) tick();
        tick();
        check("held_done", bus.done, 1);
        tick();
        check("held_idle_busy", bus.busy, 0);
        check("held_idle_done", bus.done, 0);
        check("held_idle_trial", bus.trial, 0);
        tick();
        bus.start = 1'b0;
        check("held_restart_busy", bus.busy, 1);
        check("held_restart_trial", bus.trial, 8);
        begin
            int guard;
            guard = 0;
            while (bus.done !== 1'b1 && guard < W + 4) begin
                tick();
                guard++;
            end
            check("held_second_done", bus.done, 1);
            check("held_second_result", bus.result, 1);
        end
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sar_search.md
Name: sar_search

Overview:
- Successive-approximation search engine; the inverse of a magnitude comparator.
- It drives a trial value into an external comparator and reads back the gt/lt/eq verdict. From that it resolves an unknown WIDTH-bit target, MSB first, one bit per clock.
- Sits beside the existing comparator datapath. Used for threshold search and for ADC-style digitisation loops.

Parameters:
- WIDTH, 4, bit width of the trial, target and result values (legal range 2..16).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a search; sampled only in IDLE.
- cmp_gt  input  1  comparator verdict: target > trial (combinational from trial, same cycle).
- cmp_lt  input  1  comparator verdict: target < trial.
- cmp_eq  input  1  comparator verdict: target == trial.
- trial  output  WIDTH  value presented to the comparator B operand.
- busy  output  1  high while a search is in progress (TRIAL state).
- done  output  1  one-cycle pulse when the result is valid.
- result  output  WIDTH  resolved target value; held until the next accepted start.
- cmp_err  output  1  search aborted on an invalid verdict; held with result.

Behaviour:
- Reset is asynchronous and active-high. Reset values: trial=0, busy=0, done=0, result=0, cmp_err=0, state=IDLE, bit index=WIDTH-1. Reset mid-search abandons the search with no done pulse.
- States and transitions:
  - IDLE: on start, trial <= 1<<(WIDTH-1), idx <= WIDTH-1, result <= 0, cmp_err <= 0, go to TRIAL. start while busy or in DONE is ignored.
  - TRIAL: busy=1. Each cycle samples cmp_* against the current trial.
    - lt: clear trial[idx].
    - gt or eq: keep trial[idx].
    - Then, if idx==0: result <= updated trial, go to DONE. Otherwise set trial[idx-1] and decrement idx.
  - DONE: done=1 for exactly one cycle, then IDLE. trial returns to 0 on entering IDLE.
- Verdict validity: exactly one of cmp_gt, cmp_lt, cmp_eq must be high in TRIAL. Zero or more than one is invalid: result <= 0, cmp_err <= 1, go to DONE immediately.
- Latency, start accepted to done: WIDTH+1 cycles (WIDTH TRIAL cycles, then DONE). With early exit it can be as short as 2 cycles.
- Back-to-back: start asserted in the DONE cycle is ignored. start asserted in the first IDLE cycle after DONE is accepted.
- cmp inputs are ignored outside TRIAL.
- Arithmetic: pure bit set/clear on trial, no adders, no wrap. Boundaries:
  - target 0 → all bits cleared.
  - target 2^WIDTH-1 → all bits kept.

Optional Feature:
- SAR_EARLY_EXIT_EN
  - Defined: cmp_eq in TRIAL sets result <= current trial and goes straight to DONE, skipping the remaining bits.
  - Undefined: eq is treated as gt and the search always runs WIDTH TRIAL cycles. The final result is identical either way; only latency differs.

Decomposition:
- Shared package sar_pkg holds:
  - state enum sar_state_t {IDLE, TRIAL, DONE};
  - function onehot3_ok for verdict validity;
  - localparam for the index width, $clog2(WIDTH).
- Single flat module; no RTL sub-module is natural.
- The bench closes the loop with a combinational comparator model: cmp_* = f(target, trial).

Test Plan:
- WIDTH=4, target=11 (macro undefined), start pulse → trial sequence 8,12,10,11 on consecutive cycles; done pulse 5 cycles after start; result=11, cmp_err=0.
- Target=0 and target=15 → trials 8,4,2,1 / 8,12,14,15; result 0 / 15.
- Target=8: with SAR_EARLY_EXIT_EN, done 2 cycles after start, result=8. Without it, trials 8,12,10,9, result=8, 5 cycles.
- Force cmp_gt=cmp_lt=1 on the second TRIAL cycle → next cycle done=1, result=0, cmp_err=1. A following start clears cmp_err.
- Assert rst during the third TRIAL cycle → asynchronously all outputs 0, no done pulse. A new start after release runs a full clean search.
- start held high through a search and its DONE cycle → only one search runs. The next one starts in the first IDLE cycle, 6 cycles after the first start.
